ram16x256_sdp: RTL and testbench

- Simple dual-port synchronous RAM: 256 words x 16 bits, one write port and one read port on a single clock.
- Serves as the sample-history buffer for the decimating FIR low-pass filter.
- The filter writes incoming samples at a circular write address and reads taps back at a computed read address.
- Must map onto FPGA block RAM: memory array is never reset, only the read output register is.

---
 rtl/ram16x256_sdp.sv | 49 ++++
 tb/tb_ram16x256_sdp.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ram16x256_sdp.sv
// Simple dual-port 256x16 RAM, one write port, one registered read port.
// Sample-history buffer for the decimating FIR; array maps to block RAM.
module ram16x256_sdp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Zero power-up image; reset never touches the array.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                  wr_en_d;
    logic [DATA_WIDTH-1:0] q_d;
    logic [DATA_WIDTH-1:0] q_q;

    // Write is blocked while reset is held; read path is always open.
    always_comb begin
        wr_en_d = wren & reset_n;
        q_d     = mem_q[rdaddress];
    end

    // Memory array write port, no reset so it infers block RAM.
    always_ff @(posedge clock) begin
        if (wr_en_d) begin
            mem_q[wraddress] <= data;
        end
    end

    // Output register: samples pre-write contents, giving old-data on collision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_ram16x256_sdp.sv
// Self-checking bench for ram16x256_sdp.
// Directed plan scenarios followed by randomized traffic against an array model.
module tb_ram16x256_sdp;

    logic        clock;
    logic        reset_n;
    logic [15:0] data;
    logic [7:0]  wraddress;
    logic        wren;
    logic [7:0]  rdaddress;
    logic [15:0] q;

    int errors;
    int checks;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_q;

    ram16x256_sdp dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .q         (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, then compare.
    task automatic cyc(input logic we, input logic [7:0] wa,
                       input logic [15:0] d, input logic [7:0] ra);
        wren      = we;
        wraddress = wa;
        data      = d;
        rdaddress = ra;
        @(posedge clock);
        if (reset_n) begin
            ref_q = ref_mem[rdaddress];
            if (wren) ref_mem[wraddress] = data;
        end
        #1;
        chk("model_q", q, ref_q);
        @(negedge clock);
    endtask

    task automatic async_reset_pulse(input int cycles);
        #2;
        reset_n = 1'b0;
        ref_q = '0;
        #1;
        chk("async_rst_q", q, 16'h0000);
        @(negedge clock);
        for (int i = 0; i < cycles; i++) begin
            cyc(1'b1, 8'($urandom), 16'($urandom), 8'($urandom));
        end
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        errors = 0;
        checks = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_q     = '0;
        reset_n   = 1'b0;
        wren      = 1'b0;
        data      = '0;
        wraddress = '0;
        rdaddress = '0;
        #1;
        chk("reset_q", q, 16'h0000);
        @(negedge clock);
        @(negedge clock);
        chk("reset_hold_q", q, 16'h0000);
        reset_n = 1'b1;

        cyc(1'b0, 8'd0, 16'h0000, 8'd3);
        chk("powerup_zero", q, 16'h0000);

        cyc(1'b1, 8'd5, 16'h1234, 8'd0);
        cyc(1'b1, 8'd6, 16'hBEEF, 8'd0);
        cyc(1'b0, 8'd0, 16'h0000, 8'd5);
        chk("basic_a5", q, 16'h1234);
        cyc(1'b0, 8'd0, 16'h0000, 8'd6);
        chk("basic_a6", q, 16'hBEEF);

        chk("pre_rst_q", q, 16'hBEEF);
        #2;
        reset_n = 1'b0;
        ref_q = '0;
        #1;
        chk("mid_rst_q", q, 16'h0000);
        @(negedge clock);
        cyc(1'b1, 8'd6, 16'h5555, 8'd6);
        cyc(1'b1, 8'd5, 16'hAAAA, 8'd5);
        chk("rst_hold_q", q, 16'h0000);
        reset_n = 1'b1;
        cyc(1'b0, 8'd0, 16'h0000, 8'd6);
        chk("rst_keep_a6", q, 16'hBEEF);
        cyc(1'b0, 8'd0, 16'h0000, 8'd5);
        chk("rst_keep_a5", q, 16'h1234);

        cyc(1'b1, 8'd0,   16'h8000, 8'd1);
        cyc(1'b1, 8'd255, 16'h7FFF, 8'd1);
        cyc(1'b0, 8'd0,   16'hFFFF, 8'd0);
        chk("bound_a0", q, 16'h8000);
        cyc(1'b0, 8'd0,   16'hFFFF, 8'd255);
        chk("bound_a255", q, 16'h7FFF);
        cyc(1'b0, 8'd0,   16'hFFFF, 8'd0);
        chk("wren0_a0", q, 16'h8000);

        cyc(1'b1, 8'd10, 16'h0001, 8'd0);
        cyc(1'b1, 8'd10, 16'h00AA, 8'd10);
        chk("rdw_old", q, 16'h0001);
        cyc(1'b0, 8'd10, 16'h0000, 8'd10);
        chk("rdw_new", q, 16'h00AA);

        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 8'(i), 16'(i * 3), 8'(255 - i));
        end
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 8'd0, 16'h0000, 8'(i));
            v = 16'(i * 3);
            chk("latency", q, v);
        end

        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 8'(i % 256), 16'(i), 8'd0);
        end
        for (int k = 0; k < 256; k++) begin
            cyc(1'b0, 8'd0, 16'h0000, 8'((44 + k) % 256));
            v = 16'(44 + k);
            chk("circ", q, v);
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset_pulse(int'($urandom_range(0, 3)));
            end
            cyc(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom),
                8'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
